// File: rtl/data_mem_io.sv
// Data memory and I/O block for a single-cycle core: 240-byte RAM, a TX byte FIFO,
// a free-running timer, and a synchronized input port, all decoded from one byte address.
module data_mem_io #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       memwrite,
    input  logic [7:0] addr,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    input  logic [7:0] in_port,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int RAM_WORDS = 240;

    localparam logic [7:0] ADDR_TXDATA = 8'hF0;
    localparam logic [7:0] ADDR_STATUS = 8'hF1;
    localparam logic [7:0] ADDR_TIMER  = 8'hF2;
    localparam logic [7:0] ADDR_INPORT = 8'hF3;

    logic [7:0]       ram_q  [RAM_WORDS];
    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       timer_q, timer_d;
    logic [7:0]       sync1_q, sync2_q;

    logic wr_ram, wr_tx, wr_status, wr_timer;
    logic full, empty, pop, push;
    logic [3:0] count_ext;
    logic [7:0] status;

    assign wr_ram    = memwrite && (addr < ADDR_TXDATA) && !reset;
    assign wr_tx     = memwrite && (addr == ADDR_TXDATA);
    assign wr_status = memwrite && (addr == ADDR_STATUS);
    assign wr_timer  = memwrite && (addr == ADDR_TIMER);

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = wr_tx && (!full || pop);

    assign count_ext = 4'(count_q);
    assign status    = {ovf_q, 2'b00, empty, full, count_ext[2:0]};

    assign out_valid = !empty;
    assign out_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        timer_d  = wr_timer ? writedata : timer_q + 8'd1;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (wr_status && writedata[7])     ovf_d = 1'b0;
        else if (wr_tx && full && !pop)    ovf_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            timer_q  <= 8'h00;
            sync1_q  <= 8'h00;
            sync2_q  <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            timer_q  <= timer_d;
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
        end
    end

    // NOTE: storage arrays carry no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (wr_ram)          ram_q[addr]        <= writedata;
        if (push && !reset)  fifo_q[wr_ptr_q]   <= writedata;
    end

    // RAM reads come from the registered array, so a same-cycle write is seen one cycle later.
    always_comb begin
        readdata = 8'h00;
        if (addr < ADDR_TXDATA) begin
            readdata = ram_q[addr];
        end else begin
            case (addr)
                ADDR_STATUS: readdata = status;
                ADDR_TIMER:  readdata = timer_q;
                ADDR_INPORT: readdata = sync2_q;
                default:     readdata = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_io.sv
// Self-checking bench for data_mem_io: directed scenarios followed by random traffic,
// all compared against a queue/array reference model of the memory map.
module tb_data_mem_io;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset, memwrite, out_ready;
    logic [7:0] addr, writedata, in_port;
    logic [7:0] readdata, out_data;
    logic       out_valid;

    data_mem_io #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit skip_ram_rd = 1'b1;

    // Reference model
    logic [7:0] mem_m [240];
    logic [7:0] fifo_m [$];
    logic [7:0] in_hist [$];
    bit         ov_m;
    logic [7:0] timer_m;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        int c = fifo_m.size();
        return {ov_m, 2'b00, c == 0, c == DEPTH, c[2:0]};
    endfunction

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        if (a < 8'hF0) return mem_m[a];
        if (a == 8'hF1) return exp_status();
        if (a == 8'hF2) return timer_m;
        if (a == 8'hF3) return in_hist[1];
        return 8'h00;
    endfunction

    task automatic model_reset();
        fifo_m.delete();
        in_hist.delete();
        in_hist.push_back(8'h00);
        in_hist.push_back(8'h00);
        ov_m    = 1'b0;
        timer_m = 8'h00;
    endtask

    // Apply inputs for one cycle and check the combinational outputs against the model.
    task automatic drive(input bit rst, input bit mw, input logic [7:0] a,
                         input logic [7:0] wd, input bit rdy, input logic [7:0] inp);
        reset = rst; memwrite = mw; addr = a; writedata = wd; out_ready = rdy; in_port = inp;
        #1;
        if (!skip_ram_rd || a >= 8'hF0) check("readdata", readdata, exp_read(a));
        check("out_valid", {7'b0, out_valid}, {7'b0, fifo_m.size() != 0});
        check("out_data", out_data, (fifo_m.size() != 0) ? fifo_m[0] : 8'h00);
    endtask

    // Clock edge plus the model's view of what that edge does.
    task automatic tick();
        bit pop_m, full_m, push_req;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            pop_m    = (fifo_m.size() != 0) && out_ready;
            full_m   = (fifo_m.size() == DEPTH);
            push_req = memwrite && (addr == 8'hF0);
            if (memwrite && addr < 8'hF0) mem_m[addr] = writedata;
            timer_m = (memwrite && addr == 8'hF2) ? writedata : timer_m + 8'd1;
            if (memwrite && addr == 8'hF1 && writedata[7]) ov_m = 1'b0;
            else if (push_req && full_m && !pop_m)        ov_m = 1'b1;
            if (pop_m) void'(fifo_m.pop_front());
            if (push_req && (!full_m || pop_m)) fifo_m.push_back(writedata);
            in_hist.push_front(in_port);
            void'(in_hist.pop_back());
        end
        #1;
    endtask

    initial begin
        logic [7:0] old_b;
        logic [7:0] tv [4];

        // Reset held for a few edges; then check reset-state outputs while still in reset.
        reset = 1'b1; memwrite = 1'b0; addr = 8'hF1; writedata = 8'h00; out_ready = 1'b0; in_port = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        drive(1, 0, 8'hF1, 8'h00, 0, 8'h00);
        check("reset_status", readdata, 8'h10);
        check("reset_out_data", out_data, 8'h00);
        tick();
        drive(1, 0, 8'hF2, 8'h00, 0, 8'h00);
        check("reset_timer", readdata, 8'h00);
        tick();

        // Give every RAM byte a known value.
        for (int i = 0; i < 240; i++) begin
            drive(0, 1, 8'(i), 8'($urandom), 0, 8'h00);
            tick();
        end
        skip_ram_rd = 1'b0;

        // RAM write then read back; same-cycle read returns the old byte.
        old_b = mem_m[8'h10];
        drive(0, 1, 8'h10, 8'h5A, 0, 8'h00);
        check("ram_rdw_old", readdata, old_b);
        tick();
        drive(0, 0, 8'h10, 8'h00, 0, 8'h00);
        check("ram_read_new", readdata, 8'h5A);
        tick();

        // Overflow: five pushes into a 4-deep FIFO with no consumer.
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1, 8'hF0, 8'(i), 0, 8'h00);
            check("txdata_read", readdata, 8'h00);
            tick();
        end
        drive(0, 0, 8'hF1, 8'h00, 0, 8'h00);
        check("status_overflow_full", readdata, 8'h8C);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 8'hF1, 8'h00, 1, 8'h00);
            check("drain_order", out_data, 8'(i));
            tick();
        end
        drive(0, 1, 8'hF1, 8'h80, 0, 8'h00);
        check("drained_valid", {7'b0, out_valid}, 8'h00);
        tick();
        drive(0, 0, 8'hF1, 8'h00, 0, 8'h00);
        check("status_cleared", readdata, 8'h10);
        tick();

        // Push while full with a same-cycle pop.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 8'hF0, 8'h11 + 8'(i), 0, 8'h00);
            tick();
        end
        drive(0, 1, 8'hF0, 8'hAA, 1, 8'h00);
        tick();
        drive(0, 0, 8'hF1, 8'h00, 0, 8'h00);
        check("full_push_pop_status", readdata, 8'h0C);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 8'hF1, 8'h00, 1, 8'h00);
            tick();
        end
        drive(0, 0, 8'hF1, 8'h00, 0, 8'h00);
        check("aa_at_head", out_data, 8'hAA);
        drive(0, 0, 8'hF1, 8'h00, 1, 8'h00);
        tick();

        // Timer load and wrap.
        tv = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        drive(0, 1, 8'hF2, 8'hFE, 0, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 8'hF2, 8'h00, 0, 8'h00);
            check("timer_seq", readdata, tv[i]);
            tick();
        end

        // Input synchronizer latency.
        drive(0, 0, 8'hF3, 8'h00, 0, 8'h00);
        tick();
        tick();
        drive(0, 0, 8'hF3, 8'h00, 0, 8'h3C);
        check("inport_n", readdata, 8'h00);
        tick();
        drive(0, 0, 8'hF3, 8'h00, 0, 8'h3C);
        check("inport_n1", readdata, 8'h00);
        tick();
        drive(0, 0, 8'hF3, 8'h00, 0, 8'h3C);
        check("inport_n2", readdata, 8'h3C);
        tick();

        // Reserved address and INPORT writes are ignored.
        drive(0, 1, 8'hF5, 8'hFF, 0, 8'h3C);
        tick();
        drive(0, 1, 8'hF3, 8'h77, 0, 8'h3C);
        check("inport_write_ignored", readdata, 8'h3C);
        tick();
        drive(0, 0, 8'hF5, 8'h00, 0, 8'h3C);
        check("reserved_read", readdata, 8'h00);
        tick();

        // Reset mid-operation discards FIFO, keeps RAM.
        drive(0, 1, 8'h20, 8'h77, 0, 8'h00);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8'hF0, 8'hC0 + 8'(i), 0, 8'h00);
            tick();
        end
        drive(1, 1, 8'hF0, 8'h99, 0, 8'h00);
        tick();
        drive(0, 0, 8'hF1, 8'h00, 0, 8'h00);
        check("reset_mid_status", readdata, 8'h10);
        check("reset_mid_valid", {7'b0, out_valid}, 8'h00);
        drive(0, 0, 8'hF2, 8'h00, 0, 8'h00);
        check("reset_mid_timer", readdata, 8'h00);
        drive(0, 0, 8'h20, 8'h00, 0, 8'h00);
        check("ram_retained", readdata, 8'h77);
        tick();

        // Random traffic biased toward the I/O registers.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 239)) : 8'($urandom_range(240, 255));
            drive($urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0, a, 8'($urandom),
                  $urandom_range(0, 2) == 0, 8'($urandom));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
